// File: rtl/test_sequencer.sv
// Run controller for the directed-test harness: launches tests one at a time,
// tallies pass/fail reports and aborts the run if a test stalls past TIMEOUT.
module test_sequencer #(
    parameter int TOTAL_TESTS = 5,
    parameter int TIMEOUT     = 10_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] test_check,
    output logic [7:0] test_num,
    output logic       test_go,
    output logic [7:0] tests_passed,
    output logic [7:0] tests_failed,
    output logic       timed_out,
    output logic [1:0] done
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [7:0]      LAST_NUM = 8'(TOTAL_TESTS - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            start_q;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      test_num_q, test_num_d;
    logic            test_go_q, test_go_d;
    logic [7:0]      tests_passed_q, tests_passed_d;
    logic [7:0]      tests_failed_q, tests_failed_d;
    logic            timed_out_q, timed_out_d;
    logic [1:0]      done_q, done_d;
    logic            start_edge;

    assign start_edge = start & ~start_q;

    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        test_num_d     = test_num_q;
        test_go_d      = 1'b0;
        tests_passed_d = tests_passed_q;
        tests_failed_d = tests_failed_q;
        timed_out_d    = timed_out_q;
        done_d         = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d        = S_LAUNCH;
                    test_go_d      = 1'b1;
                    test_num_d     = 8'd0;
                    tests_passed_d = 8'd0;
                    tests_failed_d = 8'd0;
                    timed_out_d    = 1'b0;
                    done_d         = 2'b00;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
                wd_d    = '0;
            end
            S_RUN: begin
                // A report arriving on the final watchdog cycle takes priority over the abort.
                if (test_check[0]) begin
                    if (test_check[1]) begin
                        tests_passed_d = tests_passed_q + 8'd1;
                    end else begin
                        tests_failed_d = tests_failed_q + 8'd1;
                    end
                    if (test_num_q == LAST_NUM) begin
                        state_d = S_DONE;
                        done_d  = {(tests_failed_d == 8'd0), 1'b1};
                    end else begin
                        state_d    = S_LAUNCH;
                        test_num_d = test_num_q + 8'd1;
                        test_go_d  = 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d        = S_DONE;
                    tests_failed_d = tests_failed_q + 8'd1;
                    timed_out_d    = 1'b1;
                    done_d         = 2'b01;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // start_q resets high so a start already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b1;
            wd_q           <= '0;
            test_num_q     <= 8'd0;
            test_go_q      <= 1'b0;
            tests_passed_q <= 8'd0;
            tests_failed_q <= 8'd0;
            timed_out_q    <= 1'b0;
            done_q         <= 2'b00;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            wd_q           <= wd_d;
            test_num_q     <= test_num_d;
            test_go_q      <= test_go_d;
            tests_passed_q <= tests_passed_d;
            tests_failed_q <= tests_failed_d;
            timed_out_q    <= timed_out_d;
            done_q         <= done_d;
        end
    end

    assign test_num     = test_num_q;
    assign test_go      = test_go_q;
    assign tests_passed = tests_passed_q;
    assign tests_failed = tests_failed_q;
    assign timed_out    = timed_out_q;
    assign done         = done_q;

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Synthesizable run controller for the directed-test harness. It launches numbered tests one at a time, collects each test's pass/fail report, and counts results. A per-test watchdog aborts the run if a test stalls. A two-bit done status is returned to the top-level test harness. It sits between the harness start/done handshake and the individual test drivers, and replaces the ad-hoc test_num/timeout bookkeeping in each testbench.

## Interface
- TOTAL_TESTS, 5: number of tests per run; legal range 1..255.
- TIMEOUT, 10_000: maximum RUN cycles allowed per test before abort; must be ≥1.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset (asserts immediately, release is synchronous to clk).
- start  input  1  level; a rising edge (internally edge-detected) starts a run.
- test_check  input  2  [0] = report valid strobe, [1] = 1 means pass, 0 means fail; sampled only in RUN.
- test_num  output  8  index of the current test.
- test_go  output  1  one-cycle launch pulse for test test_num.
- tests_passed  output  8  pass count for the current run.
- tests_failed  output  8  fail count for the current run, including timeouts.
- timed_out  output  1  sticky; a watchdog abort occurred in this run.
- done  output  2  [0] = run finished, [1] = run passed (tests_failed==0); [1] is valid only when [0]=1.

## Operation
- States: IDLE, LAUNCH, RUN, DONE. All outputs are registered.
- IDLE:
  - Start edge → LAUNCH.
  - On that transition: test_num=0, tests_passed=0, tests_failed=0, timed_out=0, done=0.
- LAUNCH:
  - test_go=1 for exactly this cycle.
  - Watchdog cleared to 0.
  - Next state is RUN unconditionally.
- RUN:
  - If test_check[0]=1:
    - test_check[1]=1 increments tests_passed; 0 increments tests_failed.
    - If test_num==TOTAL_TESTS-1 → DONE; else test_num+1 → LAUNCH.
  - Else if watchdog==TIMEOUT-1:
    - tests_failed+1, timed_out=1 → DONE. Remaining tests are not launched.
    - test_num holds the stalled test's index.
  - Else watchdog+1.
- DONE:
  - done[0]=1, done[1]=(tests_failed==0); both held.
  - A new start edge re-enters LAUNCH with the same clears as IDLE.
- Watchdog width is $clog2(TIMEOUT)+1 bits. Counters cannot overflow because TOTAL_TESTS≤255.

## Timing
- Reset values: state=IDLE; test_num=0, test_go=0, tests_passed=0, tests_failed=0, timed_out=0, done=2'b00.
- Start edge sampled in cycle N → LAUNCH (test_go=1) in N+1 → RUN from N+2.
- Report sampled in RUN cycle M:
  - Counters update at M+1.
  - Next test_go at M+1 with the incremented test_num, or done[0]=1 at M+1 for the last test.
- Minimum per-test period is 2 cycles (LAUNCH + one RUN cycle).
- Timeout: with no report, the abort is registered exactly TIMEOUT RUN cycles after LAUNCH, so done[0] and timed_out rise at LAUNCH+TIMEOUT+1.
- A report in the same cycle the watchdog reaches TIMEOUT-1 wins; no timeout occurs.
- test_check[0] in IDLE, LAUNCH or DONE is ignored (no count, no state change).
- A start held high gives one edge and one run. A start edge during LAUNCH/RUN is ignored.
- rst_n low mid-run: all outputs return to reset values asynchronously. After release the block stays in IDLE until a fresh start edge; a start still high at release does not count as an edge.

## Test plan
- TOTAL_TESTS=5, each test answered 3 RUN cycles after test_go with check=2'b11:
  - five test_go pulses, test_num 0..4;
  - tests_passed=5, tests_failed=0;
  - done=2'b11 one cycle after the 5th report.
- Test 2 answered 2'b01, all others 2'b11 → tests_passed=4, tests_failed=1, done=2'b01, timed_out=0.
- TIMEOUT=16, test 1 never answered:
  - done[0] and timed_out rise 17 cycles after test 1's test_go;
  - test_num=1, tests_failed=1, no further test_go.
- TIMEOUT=16, report 2'b11 on the 16th RUN cycle → counted as pass, no timeout, test_num advances.
- rst_n pulsed low during test 3 → outputs zero immediately; no test_go until a new start edge; the rerun starts from test_num=0.
- check strobes while in DONE → counts unchanged. A second start edge → counters cleared, full rerun with identical results.
